// File: rtl/instr_fetch.sv
// Instruction fetch stage: prefetches sequential words over a req/ack memory
// handshake into a small FIFO and presents the head entry to the core as RI.
module instr_fetch #(
    parameter int unsigned       DEPTH    = 2,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cp_load,
    input  logic [ADDR_W-1:0] cp_in,
    input  logic              ri_ready,
    output logic [DATA_W-1:0] RI,
    output logic [ADDR_W-1:0] ri_pc,
    output logic              ri_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t state, state_d;

    logic [DATA_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, count_d;
    logic [ADDR_W-1:0] nxt_pc, nxt_pc_d, mem_addr_d, addr_inc;
    logic              mem_req_d, push, pop;

    assign ri_valid = (count != '0);
    assign RI       = ri_valid ? fifo_instr[head] : '0;
    assign ri_pc    = ri_valid ? fifo_pc[head] : '0;
    assign addr_inc = mem_addr + ADDR_W'(1);

    always_comb begin
        state_d    = state;
        mem_req_d  = mem_req;
        mem_addr_d = mem_addr;
        push       = (state == REQ) && mem_ack && !cp_load;
        pop        = ri_valid && ri_ready && !cp_load;
        count_d    = cp_load ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        nxt_pc_d   = cp_load ? cp_in : nxt_pc;
        unique case (state)
            IDLE: begin
                if (count_d < FULL) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = nxt_pc_d;
                end
            end
            REQ: begin
                // nxt_pc_d is the sequential successor, or the redirect target
                // when cp_load drops the acked word (count_d is then zero).
                if (mem_ack) begin
                    if (!cp_load) nxt_pc_d = addr_inc;
                    if (count_d < FULL) begin
                        mem_addr_d = nxt_pc_d;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (cp_load) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d    = REQ;
                    mem_addr_d = nxt_pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            nxt_pc   <= RESET_PC;
        end else begin
            state    <= state_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
            nxt_pc   <= nxt_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_d;
            if (cp_load) begin
                tail <= head;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_instr[tail] <= mem_rdata;
            fifo_pc[tail]    <= mem_addr;
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the 16-bit multicycle core; produces the RI word the core decodes.
- Prefetches sequential words from instruction memory over a req/ack handshake into a small FIFO.
- Presents the head entry as RI/ri_valid with a ready/valid pop.
- Accepts a redirect (cp_load/cp_in) when the core's CP changes non-sequentially (jump/branch); flushes stale words on redirect.

Parameters:
- DEPTH, 2, FIFO entries (power of two, ≥2).
- ADDR_W, 16, instruction address width (word-addressed).
- DATA_W, 16, instruction width.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- cp_load  in  1  redirect strobe, one cycle.
- cp_in  in  ADDR_W  redirect target, valid with cp_load.
- ri_ready  in  1  core consumes RI this cycle.
- RI  out  DATA_W  head instruction.
- ri_pc  out  ADDR_W  address of RI.
- ri_valid  out  1  RI/ri_pc valid.
- mem_req  out  1  memory read request (registered).
- mem_addr  out  ADDR_W  request address (registered).
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  read data.

Behaviour:
Reset values:
- RI=0, ri_pc=0, ri_valid=0, mem_req=0, mem_addr=0.
- FIFO count=0, fetch pointer nxt_pc=RESET_PC, state IDLE.
- Reset overrides everything, including an in-flight request: mem_req drops next edge; an ack arriving during reset is ignored.

Memory handshake:
- Once mem_req=1, mem_req and mem_addr hold stable until the first cycle mem_ack=1.
- mem_rdata is captured in that cycle.
- At most one request is outstanding.
- mem_ack while mem_req=0 is ignored.

FIFO and output:
- Each FIFO entry holds {pc, instr}.
- RI/ri_pc are driven from the head entry registers; ri_valid = (count≠0).
- Pop occurs when ri_valid & ri_ready.
- Push on an accepted ack.
- Push and pop in the same cycle leaves count unchanged.
- Latency: ack at edge t gives data on RI at t+1 when the FIFO was empty.

State machine:
- IDLE: if count_next < DEPTH, go to REQ with mem_req←1 and mem_addr←nxt_pc. count_next includes this cycle's pop.
- REQ, mem_ack=1: push {mem_addr, mem_rdata} and set nxt_pc←mem_addr+1.
  - If room remains after push/pop, stay in REQ with mem_addr←mem_addr+1 (back-to-back, no bubble).
  - Otherwise go to IDLE with mem_req←0.
- REQ, mem_ack=0: hold.
- DISCARD: mem_req stays high at the old address until mem_ack. Data is dropped with no push; then go to REQ at nxt_pc with mem_req kept high.

Redirect (cp_load=1), highest priority after reset:
- FIFO count←0 and nxt_pc←cp_in. A same-cycle pop is ignored, and ri_valid=0 next cycle.
- In IDLE: go to REQ at cp_in.
- In REQ with mem_ack=0: go to DISCARD.
- In REQ with mem_ack=1: the acked data is dropped; go to REQ at cp_in.
- In DISCARD: retarget only, so nxt_pc←cp_in and the state stays DISCARD.

Arithmetic:
- Addresses increment by 1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.

Boundaries:
- FIFO full: no new request is issued. An in-flight request always has a reserved slot, because a request is only issued when count_next < DEPTH.
- Empty FIFO with ri_ready=1: no effect.

Test Plan:
1. Reset then zero-wait memory (ack same cycle as req), ri_ready=1 continuously, mem[n]=0x1000+n → mem_addr 0,1,2,… every cycle with no bubble. RI sequence is 0x1000,0x1001,… with ri_pc matching; the first ri_valid is 2 cycles after rst goes high.
2. ri_ready=0, DEPTH=2 → exactly 2 acks accepted, then mem_req=0 and ri_valid=1 holding RI=0x1000. Raise ri_ready → fetch resumes at addr 2.
3. 3-cycle ack latency, cp_load with cp_in=0x0040 one cycle after a req to 0x0005 → mem_addr stays 0x0005 until ack, and that data is never on RI. Next req is 0x0040, first RI is mem[0x40] with ri_pc=0x0040.
4. cp_load in the same cycle as mem_ack and ri_ready with count=1 → FIFO empty and ri_valid=0 next cycle, acked word dropped, next mem_addr=cp_in.
5. cp_load cp_in=0xFFFE → ri_pc sequence is 0xFFFE, 0xFFFF, 0x0000.
6. Drive rst=0 for one edge while mem_req=1 and count=2 → next cycle mem_req=0, ri_valid=0, RI=0. After release, the first request is mem_addr=RESET_PC.
